// File: rtl/deinterleaver_frame.sv
`default_nettype none
// ============================================================================
// Module   : deinterleaver_frame
// Purpose  : Buffers one interleaved frame, restores the original bit order
//            in a single cycle, and emits the bytes with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module deinterleaver_frame #(
  parameter int DATABYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_RX_En,
  output logic       o_RX_Ready,
  input  logic       i_Flush,
  output logic [7:0] o_TX_Byte,
  output logic       o_TX_Valid,
  input  logic       i_TX_Ready,
  output logic       o_Frame_Done,
  output logic       o_Busy
);

  localparam int             CW     = (DATABYTES > 1) ? $clog2(DATABYTES) : 1;
  localparam int             FW     = 8 * DATABYTES;
  localparam logic [CW-1:0]  c_LAST = CW'(DATABYTES - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DEINT   = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_rx_cnt;
  logic [CW-1:0]   r_tx_cnt;
  logic [FW-1:0]   r_in_flat;
  logic [FW-1:0]   r_out_flat;
  logic [FW-1:0]   w_deint;
  logic            r_done;
  logic            w_rx_fire;
  logic            w_rx_last;
  logic            w_tx_fire;
  logic            w_tx_last;

  assign o_RX_Ready   = (r_state == S_COLLECT);
  assign o_TX_Valid   = (r_state == S_EMIT);
  assign o_Busy       = (r_state != S_COLLECT);
  assign o_Frame_Done = r_done;
  assign o_TX_Byte    = (r_state == S_EMIT) ? r_out_flat[{r_tx_cnt, 3'b000} +: 8] : 8'h00;

  // Flush wins over every transfer in the same cycle.
  assign w_rx_fire = o_RX_Ready && i_RX_En && !i_Flush;
  assign w_rx_last = w_rx_fire && (r_rx_cnt == c_LAST);
  assign w_tx_fire = o_TX_Valid && i_TX_Ready && !i_Flush;
  assign w_tx_last = w_tx_fire && (r_tx_cnt == c_LAST);

  // Flat index f of the stored frame holds original bit D[f mod N][f div N].
  always_comb begin
    w_deint = '0;
    for (int b = 0; b < DATABYTES; b++) begin
      for (int i = 0; i < 8; i++) begin
        w_deint[b*8 + i] = r_in_flat[i*DATABYTES + b];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_Flush) begin
      w_next = S_COLLECT;
    end else begin
      case (r_state)
        S_COLLECT: if (w_rx_last) w_next = S_DEINT;
        S_DEINT:   w_next = S_EMIT;
        S_EMIT:    if (w_tx_last) w_next = S_COLLECT;
        default:   w_next = S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_in_flat  <= '0;
      r_out_flat <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_tx_last;
      if (i_Flush) begin
        r_rx_cnt <= '0;
        r_tx_cnt <= '0;
      end else begin
        if (w_rx_fire) begin
          r_in_flat[{r_rx_cnt, 3'b000} +: 8] <= i_RX_Byte;
          if (!w_rx_last) r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        if (r_state == S_DEINT) begin
          r_out_flat <= w_deint;
          r_tx_cnt   <= '0;
        end
        if (w_tx_fire && !w_tx_last) r_tx_cnt <= r_tx_cnt + 1'b1;
        if (w_tx_last) r_rx_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_deinterleaver_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_deinterleaver_frame
// Purpose  : Self-checking bench for deinterleaver_frame at N=8 and N=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deinterleaver_frame;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] rx_byte, tx_byte;
  logic       rx_en, rx_ready, flush, tx_valid, tx_ready, done, busy;
  logic [7:0] rx_byte4, tx_byte4;
  logic       rx_en4, rx_ready4, flush4, tx_valid4, tx_ready4, done4, busy4;

  deinterleaver_frame #(.DATABYTES(8)) u_dut8 (
    .clk(clk), .rst(rst), .i_RX_Byte(rx_byte), .i_RX_En(rx_en), .o_RX_Ready(rx_ready),
    .i_Flush(flush), .o_TX_Byte(tx_byte), .o_TX_Valid(tx_valid), .i_TX_Ready(tx_ready),
    .o_Frame_Done(done), .o_Busy(busy));

  deinterleaver_frame #(.DATABYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_RX_Byte(rx_byte4), .i_RX_En(rx_en4), .o_RX_Ready(rx_ready4),
    .i_Flush(flush4), .o_TX_Byte(tx_byte4), .o_TX_Valid(tx_valid4), .i_TX_Ready(tx_ready4),
    .o_Frame_Done(done4), .o_Busy(busy4));

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic [63:0] din;
    logic [63:0] dexp;
    int          mode;   // 0: ready high, 1: ready toggles, 2: random ready
    logic        junk;   // offer bytes while the block is busy
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference interleaver: interleaved flat bit f = D[f mod n][f div n].
  function automatic logic [63:0] interleave(input int n, input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int f = 0; f < n*8; f++) r[f] = d[(f % n)*8 + f/n];
    return r;
  endfunction

  function automatic logic pick_ready(input int mode, inout logic tog);
    logic r;
    if (mode == 0)      r = 1'b1;
    else if (mode == 1) begin r = tog; tog = ~tog; end
    else                r = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic send8(input logic [63:0] din);
    for (int m = 0; m < 8; m++) begin
      @(negedge clk); rx_en = 1'b1; rx_byte = din[8*m +: 8];
    end
    @(negedge clk); rx_en = 1'b0;
  endtask

  task automatic run_frame8(input logic [63:0] din, input logic [63:0] dexp,
                            input int mode, input logic junk, input string nm);
    int   idx;
    int   cyc;
    logic tog;
    logic r;
    send8(din);
    rx_en = junk; rx_byte = 8'hAA;
    chk({nm, " deint ready"}, rx_ready, 0);
    chk({nm, " deint valid"}, tx_valid, 0);
    chk({nm, " deint busy"}, busy, 1);
    @(negedge clk);
    chk({nm, " latency valid"}, tx_valid, 1);
    idx = 0; cyc = 0; tog = 1'b1;
    while (idx < 8 && cyc < 100) begin
      chk({nm, " byte"}, {tx_valid, tx_byte}, {1'b1, dexp[8*idx +: 8]});
      r = pick_ready(mode, tog);
      tx_ready = r;
      if (r && tx_valid) idx++;
      cyc++;
      @(negedge clk);
    end
    rx_en = 1'b0; tx_ready = 1'b1;
    if (idx < 8) chk({nm, " timeout"}, idx, 8);
    chk({nm, " done pulse"}, done, 1);
    chk({nm, " valid after"}, tx_valid, 0);
    chk({nm, " ready back"}, rx_ready, 1);
    chk({nm, " busy after"}, busy, 0);
    @(negedge clk);
    chk({nm, " done single"}, done, 0);
  endtask

  task automatic run_frame4(input logic [31:0] din, input logic [31:0] dexp,
                            input int mode, input string nm);
    int   idx;
    int   cyc;
    logic tog;
    logic r;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk); rx_en4 = 1'b1; rx_byte4 = din[8*m +: 8];
    end
    @(negedge clk); rx_en4 = 1'b0;
    @(negedge clk);
    chk({nm, " latency valid"}, tx_valid4, 1);
    idx = 0; cyc = 0; tog = 1'b1;
    while (idx < 4 && cyc < 100) begin
      chk({nm, " byte"}, {tx_valid4, tx_byte4}, {1'b1, dexp[8*idx +: 8]});
      r = pick_ready(mode, tog);
      tx_ready4 = r;
      if (r && tx_valid4) idx++;
      cyc++;
      @(negedge clk);
    end
    tx_ready4 = 1'b1;
    if (idx < 4) chk({nm, " timeout"}, idx, 4);
    chk({nm, " done pulse"}, done4, 1);
    chk({nm, " ready back"}, rx_ready4, 1);
  endtask

  localparam logic [63:0] c_TEST_IN  = 64'h00000000_80786655;
  localparam logic [63:0] c_TEST_OUT = 64'h08070605_04030201;

  initial begin
    logic [63:0] d;
    logic [31:0] d4;
    logic [63:0] tmp;

    tbl[0] = '{din: c_TEST_IN,             dexp: c_TEST_OUT,            mode: 0, junk: 1'b0};
    tbl[1] = '{din: c_TEST_IN,             dexp: c_TEST_OUT,            mode: 1, junk: 1'b0};
    tbl[2] = '{din: 64'hFFFFFFFF_FFFFFFFF, dexp: 64'hFFFFFFFF_FFFFFFFF, mode: 0, junk: 1'b1};
    tbl[3] = '{din: 64'h80402010_08040201, dexp: 64'h80402010_08040201, mode: 1, junk: 1'b1};

    rst = 1'b1; rx_en = 0; rx_byte = 0; flush = 0; tx_ready = 1;
    rx_en4 = 0; rx_byte4 = 0; flush4 = 0; tx_ready4 = 1;
    repeat (2) @(negedge clk);
    chk("reset rx_ready", rx_ready, 1);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_byte", tx_byte, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    chk("reset rx_ready4", rx_ready4, 1);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) run_frame8(tbl[k].din, tbl[k].dexp, tbl[k].mode, tbl[k].junk, $sformatf("tbl%0d", k));

    // Flush part way through collection; the byte in the flush cycle is dropped.
    for (int m = 0; m < 3; m++) begin
      @(negedge clk); rx_en = 1'b1; rx_byte = 8'h11 * 8'(m + 1);
    end
    @(negedge clk); rx_byte = 8'hEE; flush = 1'b1;
    @(negedge clk); rx_en = 1'b0; flush = 1'b0;
    chk("flushC ready", rx_ready, 1);
    chk("flushC busy", busy, 0);
    run_frame8(c_TEST_IN, c_TEST_OUT, 0, 1'b0, "after flushC");

    // Flush during emission: no done pulse, back to collect.
    send8(c_TEST_IN);
    @(negedge clk);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("flushE mid byte", tx_byte, 8'h03);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flushE valid", tx_valid, 0);
    chk("flushE done", done, 0);
    chk("flushE ready", rx_ready, 1);
    @(negedge clk);
    chk("flushE done later", done, 0);
    run_frame8(c_TEST_IN, c_TEST_OUT, 2, 1'b0, "after flushE");

    // Asynchronous reset after four output transfers.
    send8(c_TEST_IN);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("pre-rst byte", {tx_valid, tx_byte}, {1'b1, 8'h05});
    #2 rst = 1'b1;
    #1;
    chk("arst valid", tx_valid, 0);
    chk("arst byte", tx_byte, 0);
    chk("arst ready", rx_ready, 1);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    @(negedge clk); rst = 1'b0;
    run_frame8(c_TEST_IN, c_TEST_OUT, 0, 1'b0, "after rst");

    for (int k = 0; k < 6; k++) begin
      d = {$urandom, $urandom};
      run_frame8(interleave(8, d), d, 2, k[0], $sformatf("rand8_%0d", k));
    end

    tmp = interleave(4, 64'h0F_F0_3C_A5);
    run_frame4(tmp[31:0], 32'h0F_F0_3C_A5, 0, "n4 vec");
    for (int k = 0; k < 4; k++) begin
      d4 = $urandom;
      tmp = interleave(4, {32'h0, d4});
      run_frame4(tmp[31:0], d4, 2, $sformatf("rand4_%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/deinterleaver_frame.md
Name: deinterleaver_frame

Overview:
- Inverse of the SPI-fed bit interleaver: accepts one frame of DATABYTES interleaved bytes over a valid/ready byte interface and buffers the full frame.
- Restores the original bit order with a one-cycle transpose, then emits the original bytes in order over a valid/ready byte interface with backpressure.
- Sits on the receive side of the link, between the byte deserializer and the consumer.

Parameters:
- DATABYTES, 8, bytes per frame (N); N >= 2.

Ports:
- clk, in, 1, system clock, all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- i_RX_Byte, in, 8, interleaved input byte.
- i_RX_En, in, 1, input byte valid.
- o_RX_Ready, out, 1, block can accept an input byte.
- i_Flush, in, 1, discard the current frame and return to COLLECT.
- o_TX_Byte, out, 8, deinterleaved output byte.
- o_TX_Valid, out, 1, o_TX_Byte valid.
- i_TX_Ready, in, 1, consumer accepts o_TX_Byte.
- o_Frame_Done, out, 1, one-cycle pulse after the last output byte of a frame is transferred.
- o_Busy, out, 1, high in DEINT and EMIT.

Behaviour:
- Bit mapping: original byte b, bit i (bit 0 = LSB) is written D[b][i]. The interleaver's flat index is f = m*8+p, where m is the interleaved byte index and p its bit. Interleaved bit(m,p) = D[f mod N][f div N]. The deinterleaver inverts this exactly: D[b][i] = interleaved bit at f = i*N+b. For N=8 this reduces to a transpose: D[b][i] = I[i][b].
- Ordering: the first accepted input byte is interleaved byte m=0. Output order is D[0] first through D[N-1].
- Reset (async, any state): state = COLLECT, byte counters = 0, buffers = 0, o_RX_Ready=1, o_TX_Valid=0, o_TX_Byte=0, o_Frame_Done=0, o_Busy=0.
- COLLECT:
  - o_RX_Ready=1.
  - A byte transfers when i_RX_En && o_RX_Ready; it is written to slot rx_cnt and rx_cnt increments.
  - When slot N-1 is written, go to DEINT next cycle; o_RX_Ready drops in the same next cycle.
  - i_RX_En with o_RX_Ready=0 is ignored; the byte is not stored.
- DEINT (exactly 1 cycle):
  - Register the full deinterleaved frame into the output buffer.
  - Set tx_cnt=0, go to EMIT.
- EMIT:
  - o_TX_Valid=1, o_TX_Byte = out_buf[tx_cnt].
  - A byte transfers when o_TX_Valid && i_TX_Ready.
  - While i_TX_Ready=0, o_TX_Byte and o_TX_Valid hold stable.
  - On transfer of byte N-1: o_TX_Valid=0 next cycle, o_Frame_Done=1 for that one cycle, state = COLLECT, rx_cnt=0.
- Latency: last input byte accepted in cycle t -> o_TX_Valid=1 with D[0] in cycle t+2. With i_TX_Ready held high, N output bytes appear in N consecutive cycles.
- Frame turnaround: o_RX_Ready returns to 1 in the cycle after the final output transfer. There is no overlap between collecting and emitting.
- i_Flush:
  - Synchronous, and has priority over all other events in the same cycle.
  - Next cycle: state = COLLECT, rx_cnt=0, tx_cnt=0, o_TX_Valid=0, no o_Frame_Done pulse.
  - A byte presented in the flush cycle is dropped.
- Counters: rx_cnt and tx_cnt are $clog2(N) bits wide and never wrap within a frame.
- o_Busy = (state != COLLECT).

Test Plan:
- N=8, i_TX_Ready=1; send 0x55,0x66,0x78,0x80,0x00,0x00,0x00,0x00 -> outputs 0x01..0x08 in consecutive cycles, o_TX_Valid first high 2 cycles after the last input, one o_Frame_Done pulse, o_RX_Ready returns high.
- Same frame with i_TX_Ready toggling 1/0 every cycle -> same 8 bytes in order, each held stable while not ready, no duplicates or drops.
- Two frames back-to-back; second is all 0xFF -> second output frame is 8x 0xFF; input bytes offered while o_RX_Ready=0 are not stored.
- Send 3 bytes, pulse i_Flush, then send the full frame from the first scenario -> output is exactly 0x01..0x08.
- Assert rst mid-EMIT (after 4 output bytes) -> outputs go to reset values immediately, with no clock edge needed; a subsequent full frame deinterleaves correctly.
- N=4 (non-square case): send the interleave of D = 0xA5,0x3C,0xF0,0x0F, computed by the mapping above -> outputs 0xA5,0x3C,0xF0,0x0F.
